cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Execution sequencer for the single-cycle RV32I core.
- Produces `cpu_en_o`, which gates the PC register load, `rd_wren` and `lsu_wren`. The core advances exactly one instruction per cycle in which `cpu_en_o`=1.
- Supports HALT / free RUN / single STEP, PC breakpoints and EBREAK.
- Driven from the board push button (`sw_button`) through an internal synchroniser and debouncer.
- Also provides a retired-instruction counter mappable into LSU I/O space.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level (10 ms at 50 MHz); must be >= 2.
- EBREAK_INSTR, 32'h00100073, instruction encoding treated as a software breakpoint.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sw_button  in  1  raw asynchronous push button, active-high
- mode_i  in  1  1 = run, 0 = step; sampled on an accepted button press
- pc_i  in  32  current PC (PC register output)
- instr_i  in  32  instruction at pc_i
- bkpt_en_i  in  1  PC breakpoint enable
- bkpt_addr_i  in  32  PC breakpoint address
- cpu_en_o  out  1  core advance enable (combinational from state and current inputs)
- state_o  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK
- halted_o  out  1  1 when state is HALT or BREAK
- instret_o  out  32  retired-instruction count

Behaviour:
- Reset (`rst`=1 at posedge `clk`):
  - state HALT, `instret_o`=0, synchroniser flops 0, debounce counter 0, debounced level 0, press pulse 0.
  - `cpu_en_o` is forced 0 in any cycle where `rst`=1.
  - Reset mid-RUN/STEP takes effect at that edge; no partial step survives.
- Button path:
  - 2-flop synchroniser, then a counter.
  - When the synchronised level differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates. Any agreeing sample clears the counter.
  - A debounced 0->1 transition gives `press`, a one-cycle pulse; 1->0 gives nothing.
  - Latency from a stable raw edge to `press`: DEBOUNCE_CYCLES+2 cycles.
- Definitions:
  - hit = `bkpt_en_i` && (`pc_i` == `bkpt_addr_i`)
  - brk = (`instr_i` == EBREAK_INSTR)
- `cpu_en_o`:
  - 1 when state==STEP.
  - 1 when state==RUN && !hit && !brk.
  - 0 otherwise.
  - Effect: a breakpoint or EBREAK instruction is never executed in RUN.
- Transitions (evaluated at posedge):
  - HALT: `press` && `mode_i` -> RUN; `press` && !`mode_i` -> STEP; else stay.
  - STEP: -> HALT unconditionally. Exactly one instruction executes. hit and brk are ignored in STEP, so stepping advances past a breakpoint or EBREAK (PC+4).
  - RUN: hit || brk -> BREAK (priority over `press`); else `press` -> HALT; else stay.
  - BREAK: `press` -> STEP regardless of `mode_i`; else stay.
- `instret_o`:
  - Increments by 1 on each edge with `cpu_en_o`=1.
  - Saturates at 32'hFFFFFFFF, no wrap.
  - Only `rst` clears it.
- `halted_o` and `state_o` are registered-state decodes; they change the cycle after the transition edge.
- Holding the button does not auto-repeat; one press yields one pulse.
- `mode_i` changes while in RUN have no effect until the next `press`.

Optional Feature:
- Macro CPU_RUN_CTRL_RUN_LIMIT_EN.
- Defined:
  - Adds input `run_limit_i` [31:0] and an internal 32-bit run counter, cleared on every entry into RUN.
  - The run counter increments with `cpu_en_o` in RUN.
  - In RUN, when `run_limit_i` != 0 and the counter after increment equals `run_limit_i` -> HALT.
  - hit/brk keep priority over the limit, and the limit has priority over `press`.
  - `run_limit_i`=0 means unlimited.
- Undefined: the port and counter do not exist; RUN stops only on hit, brk, `press` or `rst`.

Test Plan:
- Reset, then button bounce: with DEBOUNCE_CYCLES=4, toggle `sw_button` 1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one `press`, 6 cycles after the final rise; state HALT->RUN (`mode_i`=1). No `press` on release.
- Single step: HALT, `mode_i`=0, press -> `cpu_en_o`=1 for exactly 1 cycle, `instret_o` 0->1, state STEP then HALT, `halted_o`=1.
- Breakpoint: RUN, `bkpt_en_i`=1, `bkpt_addr_i`=32'h0000_0010, PC stepping 0,4,8,... -> `cpu_en_o`=0 while `pc_i`=0x10, state BREAK, `instret_o`=4. Next press -> one step, PC 0x14, state HALT.
- EBREAK and simultaneous events: in RUN, `instr_i`=32'h00100073 in the same cycle as `press` -> state BREAK (not HALT), `cpu_en_o`=0, `instret_o` unchanged.
- Saturation and reset: force `instret_o` near 32'hFFFFFFFE, run 3 cycles -> holds 32'hFFFFFFFF. Assert `rst` for one cycle mid-RUN -> `cpu_en_o`=0 that cycle, next cycle state HALT, `instret_o`=0.
- Macro on: `run_limit_i`=5, press in run mode -> exactly 5 cycles of `cpu_en_o`=1, then HALT. Re-run with `run_limit_i`=0 -> runs until press.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle RV32I core, with button debounce and retired-instruction counter.
// Optional run-length limit is compiled in when CPU_RUN_CTRL_RUN_LIMIT_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] EBREAK_INSTR    = 32'h00100073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_button,
    input  logic        mode_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        bkpt_en_i,
    input  logic [31:0] bkpt_addr_i,
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
    input  logic [31:0] run_limit_i,
`endif
    output logic        cpu_en_o,
    output logic [1:0]  state_o,
    output logic        halted_o,
    output logic [31:0] instret_o
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       sync_ff;
    logic             btn_sync;
    logic [CNT_W-1:0] db_cnt;
    logic             db_level;
    logic             press;
    logic [31:0]      instret_cnt;
    logic             hit;
    logic             brk;
    logic             limit_reached;

    assign btn_sync = sync_ff[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], sw_button};
        end
    end

    // The level only flips after DEBOUNCE_CYCLES disagreeing samples in a row; only a rising flip yields a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_sync != db_level) begin
                if (db_cnt == CNT_LAST) begin
                    db_cnt   <= '0;
                    db_level <= btn_sync;
                    press    <= btn_sync;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign hit = bkpt_en_i && (pc_i == bkpt_addr_i);
    assign brk = (instr_i == EBREAK_INSTR);

`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
    logic [31:0] run_cnt;

    assign limit_reached = (run_limit_i != 32'd0) && ((run_cnt + 32'd1) == run_limit_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= 32'd0;
        end else if ((state != ST_RUN) && (state_next == ST_RUN)) begin
            run_cnt <= 32'd0;
        end else if ((state == ST_RUN) && cpu_en_o) begin
            run_cnt <= run_cnt + 32'd1;
        end
    end
`else
    assign limit_reached = 1'b0;
`endif

    // Breakpoints stop RUN before the instruction executes; STEP ignores them so it can move past one.
    always_comb begin
        state_next = state;
        cpu_en_o   = 1'b0;
        case (state)
            ST_HALT: begin
                if (press) begin
                    state_next = mode_i ? ST_RUN : ST_STEP;
                end
            end
            ST_STEP: begin
                cpu_en_o   = 1'b1;
                state_next = ST_HALT;
            end
            ST_RUN: begin
                cpu_en_o = !hit && !brk;
                if (hit || brk) begin
                    state_next = ST_BREAK;
                end else if (limit_reached || press) begin
                    state_next = ST_HALT;
                end
            end
            default: begin
                if (press) begin
                    state_next = ST_STEP;
                end
            end
        endcase
        if (rst) begin
            cpu_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HALT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_cnt <= 32'd0;
        end else if (cpu_en_o && (instret_cnt != 32'hFFFF_FFFF)) begin
            instret_cnt <= instret_cnt + 32'd1;
        end
    end

    assign instret_o = instret_cnt;
    assign state_o   = state;
    assign halted_o  = (state == ST_HALT) || (state == ST_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized button/program traffic
// compared every cycle against a behavioural model of the sequencer.
module tb_cpu_run_ctrl;

    localparam int DC = 4;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        sw_button;
    logic        mode_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        bkpt_en_i;
    logic [31:0] bkpt_addr_i;
    logic        cpu_en_o;
    logic [1:0]  state_o;
    logic        halted_o;
    logic [31:0] instret_o;
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
    logic [31:0] run_limit_i;
    logic [31:0] p_limit;
    logic [31:0] m_runcnt;
`endif

    int total;
    int bad;

    // Model state uses the architectural codes: 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
    int          m_state;
    logic [31:0] m_instret;
    logic [31:0] m_pc;
    logic        m_s0;
    logic        m_s1;
    logic        m_db;
    logic        m_press;
    logic        hist[$];

    logic        p_bkpt_en;
    logic [31:0] p_bkpt_addr;
    logic        p_ebreak;
    logic        ebreak_on_press;

    logic [1:0]  obs_state;
    logic        obs_halted;
    logic [31:0] obs_instret;
    int          en_seen;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .EBREAK_INSTR   (EBREAK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_button  (sw_button),
        .mode_i     (mode_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .bkpt_en_i  (bkpt_en_i),
        .bkpt_addr_i(bkpt_addr_i),
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
        .run_limit_i(run_limit_i),
`endif
        .cpu_en_o   (cpu_en_o),
        .state_o    (state_o),
        .halted_o   (halted_o),
        .instret_o  (instret_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic modelEn();
        logic hit;
        logic brk;
        hit = bkpt_en_i && (pc_i == bkpt_addr_i);
        brk = (instr_i == EBREAK);
        if (rst) return 1'b0;
        if (m_state == 2) return 1'b1;
        if (m_state == 1) return !(hit || brk);
        return 1'b0;
    endfunction

    task automatic modelStep();
        logic en;
        logic hit;
        logic brk;
        logic lim;
        logic all_diff;
        int   nxt;
        en = modelEn();
        if (rst) begin
            m_state   = 0;
            m_instret = 32'd0;
            m_pc      = 32'd0;
            m_s0      = 1'b0;
            m_s1      = 1'b0;
            m_db      = 1'b0;
            m_press   = 1'b0;
            hist.delete();
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
            m_runcnt  = 32'd0;
`endif
        end else begin
            hit = bkpt_en_i && (pc_i == bkpt_addr_i);
            brk = (instr_i == EBREAK);
            lim = 1'b0;
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
            lim = (run_limit_i != 32'd0) && ((m_runcnt + 32'd1) == run_limit_i);
`endif
            nxt = m_state;
            case (m_state)
                0: if (m_press) nxt = mode_i ? 1 : 2;
                1: begin
                    if (hit || brk) nxt = 3;
                    else if (lim) nxt = 0;
                    else if (m_press) nxt = 0;
                end
                2: nxt = 0;
                default: if (m_press) nxt = 2;
            endcase
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
            if (m_state == 1 && en) m_runcnt = m_runcnt + 32'd1;
            if (nxt == 1 && m_state != 1) m_runcnt = 32'd0;
`endif
            m_state = nxt;
            if (en && m_instret != 32'hFFFF_FFFF) m_instret = m_instret + 32'd1;
            if (en) m_pc = m_pc + 32'd4;
            // Debounced level flips once the last DC synchronised samples all disagree with it.
            hist.push_back(m_s1);
            if (hist.size() > DC) void'(hist.pop_front());
            m_press = 1'b0;
            if (hist.size() == DC) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
                if (all_diff) begin
                    m_db    = !m_db;
                    m_press = m_db;
                    hist.delete();
                end
            end
            m_s1 = m_s0;
            m_s0 = sw_button;
        end
    endtask

    task automatic runCycle(input logic btn, input logic md, input logic r);
        @(negedge clk);
        rst         = r;
        sw_button   = btn;
        mode_i      = md;
        bkpt_en_i   = p_bkpt_en;
        bkpt_addr_i = p_bkpt_addr;
        pc_i        = m_pc;
        instr_i     = (p_ebreak || (ebreak_on_press && m_press)) ? EBREAK : NOP;
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
        run_limit_i = p_limit;
`endif
        #1;
        obs_state   = state_o;
        obs_halted  = halted_o;
        obs_instret = instret_o;
        if (cpu_en_o) en_seen++;
        checkOutput("cpu_en", 32'(cpu_en_o), 32'(modelEn()));
        checkOutput("state", 32'(state_o), m_state);
        checkOutput("halted", 32'(halted_o), 32'((m_state == 0) || (m_state == 3)));
        checkOutput("instret", instret_o, m_instret);
        @(posedge clk);
        modelStep();
    endtask

    // One clean press: hold long enough to be accepted, then release long enough to settle.
    task automatic applyStimulus(input logic md, input int hold);
        for (int i = 0; i < hold; i++) runCycle(1'b1, md, 1'b0);
        for (int i = 0; i < hold; i++) runCycle(1'b0, md, 1'b0);
    endtask

    initial begin
        int lat;
        total = 0;
        bad = 0;
        en_seen = 0;
        p_bkpt_en = 1'b0;
        p_bkpt_addr = 32'd0;
        p_ebreak = 1'b0;
        ebreak_on_press = 1'b0;
        rst = 1'b1;
        sw_button = 1'b0;
        mode_i = 1'b0;
        pc_i = 32'd0;
        instr_i = NOP;
        bkpt_en_i = 1'b0;
        bkpt_addr_i = 32'd0;
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
        p_limit = 32'd0;
        run_limit_i = 32'd0;
`endif
        repeat (2) @(posedge clk);
        modelStep();
        runCycle(1'b0, 1'b0, 1'b1);
        runCycle(1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 32'(obs_state), 32'd0);
        checkOutput("reset_instret", obs_instret, 32'd0);

        // Bouncing button, then a steady press in run mode.
        for (int i = 0; i < 20; i++) runCycle(((i / 2) % 2) == 0, 1'b1, 1'b0);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            runCycle(1'b1, 1'b1, 1'b0);
            if (lat < 0 && obs_state == 2'b01) lat = k;
        end
        checkOutput("bounce_latency", 32'(lat), 32'(DC + 3));
        for (int i = 0; i < 20; i++) runCycle(1'b0, 1'b1, 1'b0);
        checkOutput("no_release_press", 32'(obs_state), 32'd1);
        applyStimulus(1'b0, DC + 4);
        checkOutput("run_to_halt", 32'(obs_state), 32'd0);

        // Single step.
        runCycle(1'b0, 1'b0, 1'b1);
        en_seen = 0;
        applyStimulus(1'b0, DC + 4);
        checkOutput("step_en_cycles", 32'(en_seen), 32'd1);
        checkOutput("step_instret", obs_instret, 32'd1);
        checkOutput("step_halted", 32'(obs_halted), 32'd1);
        checkOutput("step_state", 32'(obs_state), 32'd0);

        // PC breakpoint at 0x10, then step past it.
        runCycle(1'b0, 1'b1, 1'b1);
        p_bkpt_en = 1'b1;
        p_bkpt_addr = 32'h0000_0010;
        en_seen = 0;
        applyStimulus(1'b1, DC + 4);
        checkOutput("bkpt_state", 32'(obs_state), 32'd3);
        checkOutput("bkpt_instret", obs_instret, 32'd4);
        checkOutput("bkpt_pc", m_pc, 32'h0000_0010);
        applyStimulus(1'b1, DC + 4);
        checkOutput("bkpt_step_state", 32'(obs_state), 32'd0);
        checkOutput("bkpt_step_instret", obs_instret, 32'd5);
        checkOutput("bkpt_step_pc", m_pc, 32'h0000_0014);
        p_bkpt_en = 1'b0;

        // EBREAK coinciding with a press while running.
        runCycle(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, DC + 4);
        ebreak_on_press = 1'b1;
        applyStimulus(1'b0, DC + 4);
        ebreak_on_press = 1'b0;
        checkOutput("ebreak_press_state", 32'(obs_state), 32'd3);
        checkOutput("ebreak_press_instret", obs_instret, m_instret);
        applyStimulus(1'b0, DC + 4);
        checkOutput("ebreak_step_state", 32'(obs_state), 32'd0);

        // Saturation near the top, then reset mid-run.
        runCycle(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, DC + 4);
        #2;
        force dut.instret_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.instret_cnt;
        m_instret = 32'hFFFF_FFFD;
        repeat (5) runCycle(1'b0, 1'b1, 1'b0);
        checkOutput("sat_instret", obs_instret, 32'hFFFF_FFFF);
        checkOutput("sat_running", 32'(obs_state), 32'd1);
        runCycle(1'b0, 1'b1, 1'b1);
        runCycle(1'b0, 1'b1, 1'b0);
        checkOutput("midrun_reset_state", 32'(obs_state), 32'd0);
        checkOutput("midrun_reset_instret", obs_instret, 32'd0);

`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
        p_limit = 32'd5;
        en_seen = 0;
        applyStimulus(1'b1, DC + 4);
        repeat (5) runCycle(1'b0, 1'b1, 1'b0);
        checkOutput("limit_en_cycles", 32'(en_seen), 32'd5);
        checkOutput("limit_state", 32'(obs_state), 32'd0);
        p_limit = 32'd0;
        applyStimulus(1'b1, DC + 4);
        repeat (20) runCycle(1'b0, 1'b1, 1'b0);
        checkOutput("unlimited_state", 32'(obs_state), 32'd1);
        applyStimulus(1'b1, DC + 4);
        checkOutput("unlimited_halt", 32'(obs_state), 32'd0);
`endif

        // Randomized button, mode, breakpoint, EBREAK and reset traffic.
        for (int seg = 0; seg < 150; seg++) begin
            logic btn;
            logic md;
            logic r;
            int   len;
            btn = 1'($urandom_range(0, 1));
            md = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 39) == 0);
            p_bkpt_en = ($urandom_range(0, 3) == 0);
            p_bkpt_addr = m_pc + 32'(4 * $urandom_range(0, 6));
            ebreak_on_press = ($urandom_range(0, 3) == 0);
`ifdef CPU_RUN_CTRL_RUN_LIMIT_EN
            p_limit = 32'($urandom_range(0, 8));
`endif
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                p_ebreak = ($urandom_range(0, 15) == 0);
                runCycle(btn, md, r && (k == 0));
            end
        end
        p_ebreak = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
